// File: rtl/atm_keypad_entry.sv
// -----------------------------------------------------------------------------
// atm_keypad_entry
//
// Keypad front-end for the ATM controller. Collects key strokes into the
// account digit, PIN, operation, amount and new-PIN fields, then presents one
// complete transaction request with a valid/ready handshake.
//
// Ports:
//   clk          in   system clock, all state on rising edge
//   rst          in   asynchronous active-high reset
//   key_valid    in   one-cycle strobe qualifying key_code
//   key_code     in   0-9 digit, 10 ENTER, 11 CLEAR, 12 CANCEL, 13-15 illegal
//   req_ready    in   controller accepts the pending request
//   req_valid    out  complete request present (high while in S_SEND)
//   acc_num      out  account digit
//   pin          out  BCD PIN, first digit in MSB nibble
//   new_pin      out  BCD new PIN, same packing
//   amount       out  binary amount
//   operation    out  operation code (`BALANCE/`WITHDRAW/`DEPOSIT/`CHANGE_PIN)
//   entry_state  out  current FSM state
//   error        out  one-cycle pulse on a rejected key
//
// Optional feature macro: ATM_KEY_TIMEOUT_EN
//   When defined, an inactivity counter cancels an entry in S_PIN, S_OP,
//   S_AMT or S_NEWPIN after TIMEOUT_CYCLES idle clocks and pulses error.
// -----------------------------------------------------------------------------

// Operation codes shared with the controller; definitions.v wins if it is
// compiled first.
`ifndef BALANCE
`define BALANCE 3'd0
`endif
`ifndef WITHDRAW
`define WITHDRAW 3'd1
`endif
`ifndef DEPOSIT
`define DEPOSIT 3'd2
`endif
`ifndef CHANGE_PIN
`define CHANGE_PIN 3'd3
`endif

module atm_keypad_entry #(
  parameter int PIN_DIGITS     = 4,
  parameter int MAX_AMT_DIGITS = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    key_valid,
  input  logic [3:0]              key_code,
  input  logic                    req_ready,
  output logic                    req_valid,
  output logic [3:0]              acc_num,
  output logic [4*PIN_DIGITS-1:0] pin,
  output logic [4*PIN_DIGITS-1:0] new_pin,
  output logic [31:0]             amount,
  output logic [2:0]              operation,
  output logic [2:0]              entry_state,
  output logic                    error
);

  localparam int PW = 4 * PIN_DIGITS;

  localparam logic [2:0] S_ACC    = 3'd0;
  localparam logic [2:0] S_PIN    = 3'd1;
  localparam logic [2:0] S_OP     = 3'd2;
  localparam logic [2:0] S_AMT    = 3'd3;
  localparam logic [2:0] S_NEWPIN = 3'd4;
  localparam logic [2:0] S_SEND   = 3'd5;

  localparam logic [3:0] K_ENTER  = 4'd10;
  localparam logic [3:0] K_CLEAR  = 4'd11;
  localparam logic [3:0] K_CANCEL = 4'd12;

  logic [2:0]    state_q, state_d;
  logic [3:0]    acc_q, acc_d;
  logic [PW-1:0] pin_q, pin_d;
  logic [PW-1:0] npin_q, npin_d;
  logic [31:0]   amt_q, amt_d;
  logic [2:0]    op_q, op_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          err_q, err_d;

  // Append one BCD digit at the LSB end; the first digit entered ends up in
  // the MSB nibble once all PIN_DIGITS have been shifted in.
  function automatic logic [PW-1:0] shift_digit(input logic [PW-1:0] cur,
                                                input logic [3:0]    dig);
    shift_digit = (cur << 4) | PW'(dig);
  endfunction

  // Decimal accumulate; 9 digits always fit in 32 bits.
  function automatic logic [31:0] amt_acc(input logic [31:0] cur,
                                          input logic [3:0]  dig);
    amt_acc = cur * 32'd10 + 32'(dig);
  endfunction

  logic is_digit;
  assign is_digit = (key_code <= 4'd9);

`ifdef ATM_KEY_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_active;
  assign tmo_active = (state_q == S_PIN) || (state_q == S_OP) ||
                      (state_q == S_AMT) || (state_q == S_NEWPIN);
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    pin_d   = pin_q;
    npin_d  = npin_q;
    amt_d   = amt_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;

    if (state_q == S_SEND) begin
      // Request frozen until accepted; every key is ignored here.
      if (req_ready) state_d = S_ACC;
    end else if (key_valid) begin
      if (key_code > K_CANCEL) begin
        err_d = 1'b1;
      end else if (key_code == K_CANCEL) begin
        state_d = S_ACC;
        acc_d   = '0;
        pin_d   = '0;
        npin_d  = '0;
        amt_d   = '0;
        op_d    = '0;
        cnt_d   = '0;
      end else begin
        case (state_q)
          S_ACC: begin
            if (is_digit) begin
              acc_d   = key_code;
              pin_d   = '0;
              npin_d  = '0;
              amt_d   = '0;
              op_d    = '0;
              state_d = S_PIN;
            end
          end
          S_PIN: begin
            if (is_digit) begin
              pin_d = shift_digit(pin_q, key_code);
              cnt_d = cnt_q + 4'd1;
              if (cnt_q == 4'(PIN_DIGITS - 1)) state_d = S_OP;
            end else if (key_code == K_CLEAR) begin
              pin_d = '0;
              cnt_d = '0;
            end
          end
          S_OP: begin
            case (key_code)
              4'd1: begin op_d = `BALANCE;    state_d = S_SEND;   end
              4'd2: begin op_d = `WITHDRAW;   state_d = S_AMT;    end
              4'd3: begin op_d = `DEPOSIT;    state_d = S_AMT;    end
              4'd4: begin op_d = `CHANGE_PIN; state_d = S_NEWPIN; end
              4'd5: begin
                // Leave without a request; fields are cleared for the next user.
                state_d = S_ACC;
                acc_d   = '0;
                pin_d   = '0;
                npin_d  = '0;
                amt_d   = '0;
                op_d    = '0;
              end
              K_ENTER, K_CLEAR: ;
              default: err_d = 1'b1;
            endcase
          end
          S_AMT: begin
            if (is_digit) begin
              if (cnt_q >= 4'(MAX_AMT_DIGITS)) begin
                err_d = 1'b1;
              end else begin
                amt_d = amt_acc(amt_q, key_code);
                cnt_d = cnt_q + 4'd1;
              end
            end else if (key_code == K_ENTER) begin
              if (cnt_q != 4'd0) state_d = S_SEND;
              else               err_d   = 1'b1;
            end else begin
              amt_d = '0;
              cnt_d = '0;
            end
          end
          S_NEWPIN: begin
            if (is_digit) begin
              npin_d = shift_digit(npin_q, key_code);
              cnt_d  = cnt_q + 4'd1;
              if (cnt_q == 4'(PIN_DIGITS - 1)) state_d = S_SEND;
            end else if (key_code == K_CLEAR) begin
              npin_d = '0;
              cnt_d  = '0;
            end
          end
          default: state_d = S_ACC;
        endcase
      end
    end else if (state_q > S_SEND) begin
      state_d = S_ACC;
    end

`ifdef ATM_KEY_TIMEOUT_EN
    // Idle expiry behaves like CANCEL but is reported as an error.
    if (!key_valid && tmo_active && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1))) begin
      state_d = S_ACC;
      acc_d   = '0;
      pin_d   = '0;
      npin_d  = '0;
      amt_d   = '0;
      op_d    = '0;
      err_d   = 1'b1;
    end
`endif

    if (state_d != state_q) cnt_d = '0;
  end

`ifdef ATM_KEY_TIMEOUT_EN
  always_comb begin
    tmo_d = tmo_q;
    if (key_valid || (state_d != state_q)) tmo_d = '0;
    else if (tmo_active)                   tmo_d = tmo_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_ACC;
      acc_q   <= '0;
      pin_q   <= '0;
      npin_q  <= '0;
      amt_q   <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      pin_q   <= pin_d;
      npin_q  <= npin_d;
      amt_q   <= amt_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign req_valid   = (state_q == S_SEND);
  assign acc_num     = acc_q;
  assign pin         = pin_q;
  assign new_pin     = npin_q;
  assign amount      = amt_q;
  assign operation   = op_q;
  assign entry_state = state_q;
  assign error       = err_q;

endmodule
